// File: rtl/fnd_pkg.sv
// Shared FND bus constants: segment patterns, digit-common codes and the scan decoder state type.
// The FND driver uses the same encodings.
package fnd_pkg;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h7F;
    localparam logic [7:0] SEG_F = 8'hFF;

    localparam logic [3:0] COM_D1    = 4'b1110;
    localparam logic [3:0] COM_D10   = 4'b1101;
    localparam logic [3:0] COM_D100  = 4'b1011;
    localparam logic [3:0] COM_D1000 = 4'b0111;
    localparam logic [3:0] COM_BLANK = 4'b1111;

    typedef enum logic [2:0] {StWait, StSettle, StSample, StHold, StFrame} state_t;

    function automatic logic com_is_digit(input logic [3:0] com);
        return (com == COM_D1) || (com == COM_D10) || (com == COM_D100) || (com == COM_D1000);
    endfunction

    function automatic logic [1:0] com_index(input logic [3:0] com);
        logic [1:0] idx;
        idx = 2'd0;
        case (com)
            COM_D10:   idx = 2'd1;
            COM_D100:  idx = 2'd2;
            COM_D1000: idx = 2'd3;
            default:   idx = 2'd0;
        endcase
        return idx;
    endfunction

    // {d1000,d100,d10,d1} BCD -> binary; every term fits in 14 bits
    function automatic logic [13:0] bcd_to_bin(input logic [15:0] d);
        return 14'(d[15:12]) * 14'd1000 + 14'(d[11:8]) * 14'd100
             + 14'(d[7:4]) * 14'd10 + 14'(d[3:0]);
    endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// FND scan bus plus decoded results; master drives the pins, slave is the decoder.
interface fnd_scan_decoder_if;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;
    logic [15:0] digits;
    logic [13:0] value;
    logic        value_valid;
    logic        frame_done;
    logic        seg_error;
    logic        scan_timeout;

    modport master (
        output fnd_com, fnd_data,
        input  digits, value, value_valid, frame_done, seg_error, scan_timeout
    );

    modport slave (
        input  fnd_com, fnd_data,
        output digits, value, value_valid, frame_done, seg_error, scan_timeout
    );
endinterface

// File: rtl/seg7_to_bcd.sv
// Active-low 7-segment (+dp) pattern to hex nibble; flags unknown patterns.
module seg7_to_bcd
    import fnd_pkg::*;
(
    input  logic [7:0] fnd_data,
    output logic [3:0] bcd,
    output logic       known,
    output logic       is_decimal
);

    always_comb begin
        bcd   = 4'h0;
        known = 1'b1;
        unique case (fnd_data)
            SEG_0:   bcd = 4'h0;
            SEG_1:   bcd = 4'h1;
            SEG_2:   bcd = 4'h2;
            SEG_3:   bcd = 4'h3;
            SEG_4:   bcd = 4'h4;
            SEG_5:   bcd = 4'h5;
            SEG_6:   bcd = 4'h6;
            SEG_7:   bcd = 4'h7;
            SEG_8:   bcd = 4'h8;
            SEG_9:   bcd = 4'h9;
            SEG_A:   bcd = 4'hA;
            SEG_B:   bcd = 4'hB;
            SEG_C:   bcd = 4'hC;
            SEG_D:   bcd = 4'hD;
            SEG_E:   bcd = 4'hE;
            SEG_F:   bcd = 4'hF;
            default: known = 1'b0;
        endcase
        is_decimal = known && (bcd <= 4'd9);
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Monitors a multiplexed 4-digit FND bus and rebuilds the shown digits and their decimal value.
// One sample per settled digit dwell; a frame completes once all four positions are captured.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
    input logic              clk,
    input logic              reset,
    fnd_scan_decoder_if.slave bus
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       com_q, com_l;
    logic [7:0]       data_q;
    logic [3:0]       cur_com_q, cur_com_d;
    logic [7:0]       cur_data_q, cur_data_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [3:0][3:0]  slot_q, slot_d;
    logic [3:0]       mask_q, mask_d;
    logic [15:0]      digits_q, digits_d;
    logic [13:0]      value_q, value_d;
    logic             valid_q, valid_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             timeout_q, timeout_d;

    logic [3:0] bcd;
    logic       known, is_decimal;
    logic [1:0] cur_idx;
    logic       com_digit, com_illegal, frame_evt, sample_err, dec_ok;
    logic [3:0] new_mask;

    seg7_to_bcd u_seg7 (
        .fnd_data   (cur_data_q),
        .bcd        (bcd),
        .known      (known),
        .is_decimal (is_decimal)
    );

    assign cur_idx     = com_index(cur_com_q);
    assign com_digit   = com_is_digit(com_q);
    assign com_illegal = !com_digit && (com_q != COM_BLANK);

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        cur_com_d  = cur_com_q;
        cur_data_d = cur_data_q;
        slot_d     = slot_q;
        mask_d     = mask_q;
        digits_d   = digits_q;
        value_d    = value_q;
        valid_d    = valid_q;
        tcnt_d     = tcnt_q;
        timeout_d  = timeout_q;
        frame_evt  = 1'b0;
        sample_err = 1'b0;
        new_mask   = mask_q;
        dec_ok     = is_decimal;

        unique case (state_q)
            StWait: begin
                if (com_digit) begin
                    state_d    = StSettle;
                    settle_d   = '0;
                    cur_com_d  = com_q;
                    cur_data_d = data_q;
                end
            end
            StSettle: begin
                if (com_q != cur_com_q) begin
                    if (com_digit) begin
                        settle_d   = '0;
                        cur_com_d  = com_q;
                        cur_data_d = data_q;
                    end else begin
                        state_d = StWait;
                    end
                end else if (data_q != cur_data_q) begin
                    settle_d   = '0;
                    cur_data_d = data_q;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StSample: begin
                if (known) begin
                    slot_d[cur_idx]   = bcd;
                    new_mask[cur_idx] = 1'b1;
                end else begin
                    sample_err = 1'b1;
                end
                for (int i = 0; i < 4; i++) begin
                    if (2'(i) != cur_idx && slot_q[i] > 4'd9) dec_ok = 1'b0;
                end
                if (&new_mask) begin
                    frame_evt = 1'b1;
                    state_d   = StFrame;
                    mask_d    = '0;
                    digits_d  = slot_d;
                    valid_d   = dec_ok;
                    if (dec_ok) value_d = bcd_to_bin(slot_d);
                end else begin
                    mask_d  = new_mask;
                    state_d = StHold;
                end
            end
            StHold: begin
                // Only a new com code starts another dwell; data changes are ignored here
                if (com_q != cur_com_q) begin
                    if (com_digit) begin
                        state_d    = StSettle;
                        settle_d   = '0;
                        cur_com_d  = com_q;
                        cur_data_d = data_q;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StFrame: state_d = StHold;
            default: state_d = StWait;
        endcase

        // A frame completing in the timeout cycle suppresses the timeout
        if (frame_evt) begin
            tcnt_d    = '0;
            timeout_d = 1'b0;
        end else begin
            if (tcnt_q != TO_MAX) tcnt_d = tcnt_q + TW'(1);
            if (tcnt_q == TO_LAST) begin
                timeout_d = 1'b1;
                valid_d   = 1'b0;
                mask_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StWait;
            com_q      <= COM_BLANK;
            com_l      <= COM_BLANK;
            data_q     <= 8'hFF;
            cur_com_q  <= COM_BLANK;
            cur_data_q <= 8'hFF;
            settle_q   <= '0;
            slot_q     <= '0;
            mask_q     <= '0;
            digits_q   <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            tcnt_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            com_q      <= bus.fnd_com;
            com_l      <= com_q;
            data_q     <= bus.fnd_data;
            cur_com_q  <= cur_com_d;
            cur_data_q <= cur_data_d;
            settle_q   <= settle_d;
            slot_q     <= slot_d;
            mask_q     <= mask_d;
            digits_q   <= digits_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            tcnt_q     <= tcnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.digits       = digits_q;
    assign bus.value        = value_q;
    assign bus.value_valid  = valid_q;
    assign bus.frame_done   = (state_q == StFrame);
    // Illegal com reported once per appearance, unknown pattern once per sample
    assign bus.seg_error    = ((com_q != com_l) && com_illegal) || sample_err;
    assign bus.scan_timeout = timeout_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Randomised and directed scan stimulus for fnd_scan_decoder with a frame scoreboard.
module tb_fnd_scan_decoder;
    import fnd_pkg::*;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned TMO    = 3000;

    typedef struct packed {
        logic [15:0] digits;
        logic [13:0] value;
        logic        valid;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fnd_scan_decoder_if bus ();

    fnd_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    frame_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int seg_cnt = 0;
    int exp_seg = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h7F, 8'hFF};
    logic [3:0] com_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int  m_dig [4];
    bit  m_have [4];
    int  m_value = 0;
    logic [3:0] last_com = 4'hF;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int decode(input logic [7:0] b);
        for (int i = 0; i < 16; i++) if (seg_tab[i] == b) return i;
        return -1;
    endfunction

    // Reference: a settled dwell captures one digit; four captured positions make a frame
    task automatic model_dwell(input int idx, input logic [7:0] b);
        int d;
        bit all, dec;
        frame_t f;
        d = decode(b);
        if (d < 0) begin
            exp_seg++;
            return;
        end
        m_dig[idx]  = d;
        m_have[idx] = 1'b1;
        all = 1'b1;
        dec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!m_have[i]) all = 1'b0;
            if (m_dig[i] > 9) dec = 1'b0;
        end
        if (!all) return;
        if (dec) m_value = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
        f.digits = 16'((m_dig[3] << 12) | (m_dig[2] << 8) | (m_dig[1] << 4) | m_dig[0]);
        f.value  = 14'(m_value);
        f.valid  = dec;
        exp_q.push_back(f);
        for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
    endtask

    task automatic drive(input logic [3:0] com, input logic [7:0] data, input int len);
        if (com == last_com && com != 4'hF) begin
            bus.fnd_com  = 4'hF;
            bus.fnd_data = 8'hFF;
            repeat (2) @(negedge clk);
        end
        bus.fnd_com  = com;
        bus.fnd_data = data;
        last_com     = com;
        repeat (len) @(negedge clk);
    endtask

    task automatic scan(input int idx, input logic [7:0] data);
        model_dwell(idx, data);
        drive(com_tab[idx], data, SETTLE + 4 + $urandom_range(0, 16));
    endtask

    task automatic illegal_dwell(input int len);
        logic [3:0] c;
        do c = 4'($urandom_range(0, 15));
        while (c == 4'hF || c == com_tab[0] || c == com_tab[1] || c == com_tab[2] || c == com_tab[3]);
        exp_seg++;
        drive(c, 8'hFF, len);
    endtask

    task automatic do_reset();
        bus.fnd_com  = 4'hF;
        bus.fnd_data = 8'hFF;
        last_com     = 4'hF;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
        m_value = 0;
        check("queue_empty_at_reset", exp_q.size(), 0);
        reset = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (30) @(negedge clk);
        check({name, "_frames_pending"}, exp_q.size(), 0);
        check({name, "_seg_error_count"}, seg_cnt, exp_seg);
    endtask

    task automatic monitor();
        frame_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.seg_error) seg_cnt++;
                if (bus.frame_done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got digits 0x%0h expected no frame", bus.digits);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_digits", int'(bus.digits), int'(e.digits));
                        check("frame_value", int'(bus.value), int'(e.value));
                        check("frame_valid", int'(bus.value_valid), int'(e.valid));
                    end
                end
            end
        end
    endtask

    initial begin
        int perm[4];
        int j, t, r;
        logic [7:0] b;

        bus.fnd_com  = 4'hF;
        bus.fnd_data = 8'hFF;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_digits", int'(bus.digits), 0);
        check("rst_value", int'(bus.value), 0);
        check("rst_value_valid", int'(bus.value_valid), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_seg_error", int'(bus.seg_error), 0);
        check("rst_scan_timeout", int'(bus.scan_timeout), 0);
        reset = 1'b1;

        // Timeout exactly TMO cycles after reset with no frame
        repeat (TMO - 1) @(negedge clk);
        check("timeout_not_yet", int'(bus.scan_timeout), 0);
        @(negedge clk);
        check("timeout_set", int'(bus.scan_timeout), 1);
        check("timeout_valid", int'(bus.value_valid), 0);

        // 1234 with latency check on the completing digit
        do_reset();
        scan(0, seg_tab[4]);
        scan(1, seg_tab[3]);
        scan(2, seg_tab[2]);
        model_dwell(3, seg_tab[1]);
        bus.fnd_com  = com_tab[3];
        bus.fnd_data = seg_tab[1];
        last_com     = com_tab[3];
        repeat (SETTLE + 2) @(negedge clk);
        check("latency_early", int'(bus.frame_done), 0);
        @(negedge clk);
        check("latency_exact", int'(bus.frame_done), 1);
        repeat (10) @(negedge clk);
        drain("t1234");

        // Glitching data on d1 settles to a single sample of 1
        scan(1, seg_tab[0]);
        scan(2, seg_tab[0]);
        scan(3, seg_tab[0]);
        model_dwell(0, seg_tab[1]);
        bus.fnd_com = com_tab[0];
        last_com    = com_tab[0];
        for (int k = 0; k < 13; k++) begin
            bus.fnd_data = (k % 2 == 0) ? seg_tab[0] : seg_tab[1];
            repeat (8) @(negedge clk);
        end
        bus.fnd_data = seg_tab[1];
        repeat (SETTLE + 10) @(negedge clk);
        drain("glitch");

        // Illegal com and unknown pattern leave captured digits alone
        scan(0, seg_tab[3]);
        scan(1, seg_tab[4]);
        illegal_dwell(SETTLE + 10);
        scan(2, 8'h55);
        scan(2, seg_tab[5]);
        scan(3, seg_tab[6]);
        drain("errors");

        // Hex digit in d1000 clears valid and holds value
        scan(0, seg_tab[1]);
        scan(1, seg_tab[2]);
        scan(2, seg_tab[3]);
        scan(3, seg_tab[13]);
        drain("hexd");

        // Reset mid-frame discards partial captures
        scan(0, seg_tab[1]);
        scan(1, seg_tab[2]);
        scan(2, seg_tab[3]);
        do_reset();
        scan(3, seg_tab[9]);
        scan(0, seg_tab[9]);
        scan(1, seg_tab[9]);
        scan(2, seg_tab[9]);
        drain("reset_mid");

        // Random scans in random order with junk dwells
        for (int f = 0; f < 40; f++) begin
            perm = '{0, 1, 2, 3};
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0: drive(com_tab[$urandom_range(0, 3)], 8'($urandom),
                                 $urandom_range(2, SETTLE - 4));
                        1: illegal_dwell($urandom_range(2, SETTLE + 8));
                        default: drive(4'hF, 8'hFF, $urandom_range(2, 30));
                    endcase
                end
                r = $urandom_range(0, 99);
                if (r < 80) b = seg_tab[$urandom_range(0, 9)];
                else if (r < 90) b = seg_tab[$urandom_range(10, 15)];
                else begin
                    do b = 8'($urandom);
                    while (decode(b) >= 0);
                end
                scan(perm[i], b);
            end
        end
        drain("random");

        // Timeout drops a partial frame
        scan(0, seg_tab[5]);
        drive(4'hF, 8'hFF, TMO + 20);
        for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
        check("late_timeout", int'(bus.scan_timeout), 1);
        check("late_timeout_valid", int'(bus.value_valid), 0);
        scan(1, seg_tab[1]);
        scan(2, seg_tab[2]);
        scan(3, seg_tab[3]);
        scan(0, seg_tab[4]);
        drain("timeout_mask");
        check("timeout_cleared", int'(bus.scan_timeout), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
